hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencing controller for the five-stage core. Sits beside the
//  forwarding unit and covers the hazards forwarding cannot resolve:
//   - load-use stalls
//   - taken-branch flushes
//   - freezing the pipe while a multi-cycle mul/div unit (MDU) in EX runs.
//  Also counts stall cycles for performance monitoring.
// PARAMETERS
//  CNT_W       32   width of stall_count (saturating)
//  MD_TIMEOUT  64   max MD_BUSY cycles before abort; must be >= 2
// PORTS
//  clk             in   1      rising-edge clock
//  rst             in   1      synchronous, active-high reset
//  id_rs1          in   5      rs1 of instruction in ID
//  id_rs2          in   5      rs2 of instruction in ID
//  id_uses_rs1     in   1      ID instruction reads rs1
//  id_uses_rs2     in   1      ID instruction reads rs2
//  ex_rd           in   5      rd of instruction in EX
//  ex_mem_read     in   1      EX instruction is a load
//  ex_is_md        in   1      EX instruction is a mul/div op
//  ex_branch_taken in   1      EX resolved a taken branch or jump
//  md_done         in   1      MDU result valid (1-cycle pulse)
//  md_start        out  1      MDU start pulse
//  pc_write        out  1      1 = PC may update
//  if_id_write     out  1      1 = IF/ID may load
//  if_id_flush     out  1      1 = IF/ID loads a NOP
//  id_ex_write     out  1      1 = ID/EX may load
//  id_ex_bubble    out  1      1 = ID/EX loads a NOP (control bits zeroed)
//  ex_mem_bubble   out  1      1 = EX/MEM loads a NOP
//  md_error        out  1      sticky: MDU timed out
//  stall_count     out  CNT_W  cycles with pc_write == 0
// BEHAVIOUR
//  State
//   - FSM states: RUN, MD_BUSY. State register resets to RUN.
//   - busy_cnt (>= clog2(MD_TIMEOUT) bits) is registered.
//  Output timing
//   - Control outputs are combinational from state and inputs.
//   - While rst = 1, all controls take their defaults:
//       pc_write = if_id_write = id_ex_write = 1; all others 0.
//   - stall_count and md_error reset to 0.
//  Defaults (every cycle, unless overridden below)
//   - pc_write = if_id_write = id_ex_write = 1; all other controls 0.
//  RUN state, priority high to low
//   1) ex_is_md:
//      - md_start = 1, pc_write = 0, if_id_write = 0, id_ex_write = 0,
//        ex_mem_bubble = 1.
//      - Next state MD_BUSY; busy_cnt <= 0.
//   2) ex_branch_taken:
//      - if_id_flush = 1, id_ex_bubble = 1, pc_write = 1 (redirect).
//      - Stays in RUN.
//   3) Load-use hazard:
//      - Condition: ex_mem_read && ex_rd != 0 &&
//        ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd)).
//      - Response: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
//      - Lasts exactly 1 cycle, because the load advances out of EX.
//   - md_done is ignored in RUN.
//  MD_BUSY state
//   - md_done = 0:
//     - pc_write = if_id_write = id_ex_write = 0, ex_mem_bubble = 1.
//     - busy_cnt increments.
//     - ex_branch_taken and load-use are ignored (the pipe is frozen).
//   - md_done = 1:
//     - Defaults apply: the MDU result enters EX/MEM, the pipe advances.
//     - Next state RUN.
//   - busy_cnt == MD_TIMEOUT-1 with md_done = 0:
//     - md_error <= 1 (sticky until rst).
//     - Outputs as in the md_done cycle; next state RUN.
//   - md_start = 0 in MD_BUSY. md_start is never high for 2 consecutive cycles.
//  stall_count
//   - Increments each cycle pc_write == 0 and rst == 0.
//   - Saturates at 2^CNT_W - 1; no wrap.
//  Reset mid-operation
//   - rst during MD_BUSY returns the FSM to RUN next cycle and clears
//     busy_cnt, stall_count and md_error.
//   - md_start stays 0 while rst = 1.
// TESTING
//  T1: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1
//      -> 1 cycle pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count=1.
//  T2: ex_rd=0 with ex_mem_read=1 and id_rs1=0 -> no stall.
//      Same setup with id_uses_rs1=0 and id_rs1=ex_rd=7 -> no stall.
//  T3: ex_branch_taken=1 together with a load-use match
//      -> if_id_flush=1, id_ex_bubble=1, pc_write=1; no stall counted.
//  T4: ex_is_md=1, md_done 4 cycles after md_start
//      -> md_start 1 cycle; freeze for 4 cycles; release in the md_done cycle;
//         stall_count=4.
//  T5: MD_TIMEOUT=8, md_done never asserted
//      -> after 8 frozen cycles md_error=1, FSM in RUN.
//  T6: rst at cycle 2 of MD_BUSY -> next cycle RUN, outputs at defaults,
//      stall_count=0. CNT_W=4 saturation: 20 stall cycles -> stall_count=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the five-stage core: load-use stalls, taken-branch
// flushes, pipe freeze while the multi-cycle MDU runs, and a stall-cycle counter.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   RUN     | normal flow; resolves MDU start, branch flush, load-use
//   MD_BUSY | MDU op held in EX; pipe frozen until md_done or timeout

module hazard_ctrl #(
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_is_md,
    input  logic             ex_branch_taken,
    input  logic             md_done,
    output logic             md_start,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int                BW        = $clog2(MD_TIMEOUT);
    localparam logic [BW-1:0]     BUSY_LAST = BW'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        RUN,
        MD_BUSY
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   busy_cnt;
    logic [BW-1:0]   busy_cnt_nxt;
    logic            md_error_set;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            load_use;

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);

    always_comb begin
        md_start      = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        state_nxt     = state;
        busy_cnt_nxt  = busy_cnt;
        md_error_set  = 1'b0;

        if (!rst) begin
            case (state)
                RUN: begin
                    if (ex_is_md) begin
                        md_start      = 1'b1;
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        state_nxt     = MD_BUSY;
                        busy_cnt_nxt  = '0;
                    end else if (ex_branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        pc_write     = 1'b1;
                    end else if (load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end

                MD_BUSY: begin
                    if (md_done) begin
                        state_nxt = RUN;
                    end else if (busy_cnt == BUSY_LAST) begin
                        // give up on the MDU: release the pipe as if it had finished
                        md_error_set = 1'b1;
                        state_nxt    = RUN;
                    end else begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                        busy_cnt_nxt  = busy_cnt + 1'b1;
                    end
                end

                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            busy_cnt    <= '0;
            md_error    <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_nxt;
            busy_cnt <= busy_cnt_nxt;
            if (md_error_set) begin
                md_error <= 1'b1;
            end
            if (!pc_write && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule
